// File: rtl/qdiv_pkg.sv
// Shared types and constants for the fixed-point divide issue controller.
package qdiv_pkg;

  localparam int N_DEF = 32;
  localparam int Q_DEF = 15;

  // All-ones source for the divide-by-zero saturation magnitude; sliced to N-1 bits.
  localparam logic [63:0] SAT_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/qdiv_issue_if.sv
// Operand, divider and result signal bundle for qdiv_issue.
interface qdiv_issue_if
  import qdiv_pkg::*;
#(
  parameter int N = N_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_dividend;
  logic [N-1:0] in_divisor;

  logic         div_start;
  logic [N-1:0] div_dividend;
  logic [N-1:0] div_divisor;
  logic [N-1:0] div_quotient;
  logic         div_complete;

  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_quotient;
  logic         out_divzero;

  modport slave (
    input  in_valid, in_dividend, in_divisor, div_quotient, div_complete, out_ready,
    output in_ready, div_start, div_dividend, div_divisor, out_valid, out_quotient, out_divzero
  );

  modport master (
    output in_valid, in_dividend, in_divisor, div_quotient, div_complete, out_ready,
    input  in_ready, div_start, div_dividend, div_divisor, out_valid, out_quotient, out_divzero
  );
endinterface

// File: rtl/qdiv_issue_fifo.sv
// Operand-pair FIFO; DEPTH must be a power of two. A push while full is
// only taken when a pop happens in the same cycle.
module qdiv_issue_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/qdiv_issue.sv
// Issue controller for an external sign-magnitude fixed-point divider.
// Queues operand pairs, issues one at a time, waits out the divider's
// minimum latency, then holds the result until accepted.
// Optional: define QDIV_ISSUE_DIVZERO_EN to resolve zero divisors locally
// with a saturated quotient and the out_divzero flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight, waiting for a queued operand pair
// ST_ISSUE | operands loaded, div_start pulsed (or zero divisor resolved)
// ST_WAIT  | divider running, latency counter advancing
// ST_HOLD  | result presented on out_*, waiting for out_ready
module qdiv_issue
  import qdiv_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Q     = Q_DEF,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  qdiv_issue_if.slave  bus
);
  localparam int            CW  = $clog2(N + Q + 1) + 1;
  localparam logic [CW-1:0] LAT = CW'(N + Q);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    dividend_q, divisor_q, result_q;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [2*N-1:0]  fifo_head;
  logic            ld_ops, cap_div, start_c, valid_c;
`ifdef QDIV_ISSUE_DIVZERO_EN
  logic            divzero_q, div_by_zero, cap_zero;
  assign div_by_zero = (divisor_q[N-2:0] == '0);
`endif

  assign fifo_push = bus.in_valid && !fifo_full;

  qdiv_issue_fifo #(
    .W     (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  ({bus.in_dividend, bus.in_divisor}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    ld_ops   = 1'b0;
    cap_div  = 1'b0;
    start_c  = 1'b0;
    valid_c  = 1'b0;
`ifdef QDIV_ISSUE_DIVZERO_EN
    cap_zero = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          ld_ops   = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
`ifdef QDIV_ISSUE_DIVZERO_EN
        if (div_by_zero) begin
          cap_zero = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          start_c = 1'b1;
          state_d = ST_WAIT;
        end
`else
        start_c = 1'b1;
        state_d = ST_WAIT;
`endif
      end
      ST_WAIT: begin
        // div_complete is only trusted once the minimum latency has elapsed.
        if ((cnt_q >= LAT) && bus.div_complete) begin
          cap_div = 1'b1;
          state_d = ST_HOLD;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        valid_c = 1'b1;
        if (bus.out_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            ld_ops   = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ld_ops) begin
        dividend_q <= fifo_head[2*N-1:N];
        divisor_q  <= fifo_head[N-1:0];
      end
    end
  end

  // Result capture from the divider or from the zero-divisor shortcut.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (cap_div) begin
      result_q <= bus.div_quotient;
`ifdef QDIV_ISSUE_DIVZERO_EN
    end else if (cap_zero) begin
      result_q <= {dividend_q[N-1] ^ divisor_q[N-1], SAT_ONES[N-2:0]};
`endif
    end
  end

`ifdef QDIV_ISSUE_DIVZERO_EN
  // Divide-by-zero flag follows whichever path produced the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      divzero_q <= 1'b0;
    end else if (cap_zero) begin
      divzero_q <= 1'b1;
    end else if (cap_div) begin
      divzero_q <= 1'b0;
    end
  end
  assign bus.out_divzero = divzero_q;
`else
  assign bus.out_divzero = 1'b0;
`endif

  assign bus.in_ready     = !fifo_full;
  assign bus.div_start    = start_c;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.out_valid    = valid_c;
  assign bus.out_quotient = result_q;
endmodule

// File: tb/tb_qdiv_issue.sv
module tb_qdiv_issue;
  import qdiv_pkg::*;

  localparam int N = 32;
  localparam int Q = 15;

  logic clk;
  logic rst;

  qdiv_issue_if #(.N(N)) bus();

  qdiv_issue #(.N(N), .Q(Q), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int starts   = 0;
  int div_lat  = 20;
  int t_acc    = 0;
  logic [32:0] sb[$];
  logic [32:0] mon_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference sign-magnitude divider: (|a| << Q) / |b|, sign = xor.
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num, den, q;
    if (b[30:0] == 31'd0) return {a[31] ^ b[31], {31{1'b1}}};
    num = {33'd0, a[30:0]} << Q;
    den = {33'd0, b[30:0]};
    q   = num / den;
    return {a[31] ^ b[31], q[30:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.div_start === 1'b1) starts <= starts + 1;

  // Divider model: complete rises div_lat cycles after start and stays high until the next start.
  int dv_cnt  = 0;
  bit dv_busy = 1'b0;
  bit dv_done = 1'b0;
  always @(posedge clk) begin
    if (bus.div_start === 1'b1) begin
      bus.div_quotient <= model_div(bus.div_dividend, bus.div_divisor);
      bus.div_complete <= (div_lat == 0);
      dv_cnt  <= 0;
      dv_done <= (div_lat == 0);
      dv_busy <= (div_lat != 0);
    end else if (dv_busy) begin
      dv_cnt <= dv_cnt + 1;
      if (dv_cnt + 1 >= div_lat) begin
        bus.div_complete <= 1'b1;
        dv_busy <= 1'b0;
        dv_done <= 1'b1;
      end
    end else if (!dv_done) begin
      bus.div_complete <= 1'b0;
    end
  end

  // Scoreboard: compare each accepted result against the queued expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {32'd0, bus.out_valid}, 64'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("result", {31'd0, bus.out_divzero, bus.out_quotient}, {31'd0, mon_exp});
      end
    end
  end

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp);
    int g = 0;
    bus.in_valid    = 1'b1;
    bus.in_dividend = a;
    bus.in_divisor  = b;
    while (!bus.in_ready && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
    end else begin
      @(posedge clk); #1;
      t_acc = cyc;
      sb.push_back(exp);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    int g = 0;
    while (!bus.out_valid && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (!bus.out_valid) chk("valid_timeout", {63'd0, bus.out_valid}, 64'd1);
    lat = cyc - t_acc;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 64'd0);
    @(posedge clk); #1;
  endtask

  int lat, s0, vcnt, dz_starts;
  logic [31:0] ra, rb;
  logic [32:0] dz_exp;

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.out_ready   = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_div_start", bus.div_start, 0);
    chk("rst_quotient", bus.out_quotient, 0);
    chk("rst_divzero", bus.out_divzero, 0);

    // Basic signs and latency on an empty pipe.
    div_lat = 20;
    s0 = starts;
    push_op(32'h00018000, 32'h0000C000, {1'b0, 32'h00010000});
    wait_valid(lat);
    chk("lat_pos", lat, 50);
    chk("div_dividend_hold", bus.div_dividend, 32'h00018000);
    push_op(32'h80018000, 32'h0000C000, {1'b0, 32'h80010000});
    wait_valid(lat);
    chk("lat_neg", lat, 50);
    push_op(32'h80018000, 32'h8000C000, {1'b0, 32'h00010000});
    wait_valid(lat);
    chk("lat_negneg", lat, 50);
    @(posedge clk); #1;
    chk("starts_basic", starts - s0, 3);

    // Early complete must not shorten the wait.
    div_lat = 0;
    push_op(32'h00030000, 32'h00008000, {1'b0, 32'h00030000});
    wait_valid(lat);
    chk("lat_early_complete", lat, 50);
    @(posedge clk); #1;

    // Back-pressure: 1 in flight + 4 queued, then the 6th waits.
    div_lat = 20;
    bus.out_ready = 1'b0;
    s0 = starts;
    for (int i = 0; i < 5; i++) begin
      ra = $urandom;
      rb = $urandom | 32'h1;
      push_op(ra, rb, {1'b0, model_div(ra, rb)});
      chk("bp_in_ready", bus.in_ready, (i < 4) ? 1 : 0);
    end
    repeat (60) @(posedge clk);
    #1;
    chk("bp_hold_valid", bus.out_valid, 1);
    chk("bp_in_ready_held", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    ra = $urandom;
    rb = $urandom | 32'h1;
    push_op(ra, rb, {1'b0, model_div(ra, rb)});
    drain();
    chk("bp_starts", starts - s0, 6);

    // Zero divisor.
`ifdef QDIV_ISSUE_DIVZERO_EN
    dz_exp    = {1'b1, 32'hFFFFFFFF};
    dz_starts = 0;
`else
    dz_exp    = {1'b0, 32'hFFFFFFFF};
    dz_starts = 1;
`endif
    s0 = starts;
    push_op(32'h00018000, 32'h80000000, dz_exp);
    wait_valid(lat);
    @(posedge clk); #1;
    chk("dz_starts", starts - s0, dz_starts);

    // Reset 10 cycles into WAIT with two operations queued.
    div_lat = 20;
    s0 = starts;
    push_op(32'h00010000, 32'h00008000, {1'b0, 32'h00010000});
    push_op(32'h00020000, 32'h00008000, {1'b0, 32'h00020000});
    push_op(32'h00040000, 32'h00008000, {1'b0, 32'h00040000});
    begin
      int g = 0;
      while (starts == s0 && g < 50) begin
        @(posedge clk); #1;
        g++;
      end
    end
    chk("rst_test_started", starts - s0, 1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_div_start", bus.div_start, 0);
    chk("midrst_quotient", bus.out_quotient, 0);
    chk("midrst_divzero", bus.out_divzero, 0);
    chk("midrst_div_dividend", bus.div_dividend, 0);
    sb.delete();
    rst = 1'b0;
    s0 = starts;
    vcnt = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcnt++;
    end
    chk("post_rst_no_valid", vcnt, 0);
    chk("post_rst_no_start", starts - s0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
